// File: rtl/nh_lcd_pkg.sv
// nh_lcd_pkg: shared types and constants for the LCD pixel-path feeder.
// Holds the feeder state encoding, the FIFO size and pixel data widths, and
// the ping-pong channel indices with their one-hot ownership patterns.
package nh_lcd_pkg;

   localparam int FIFO_SIZE_W = 24;
   localparam int PIXEL_W     = 32;

   localparam int CH0 = 0;
   localparam int CH1 = 1;

   localparam logic [1:0] ACT_NONE = 2'b00;
   localparam logic [1:0] ACT_CH0  = 2'(1 << CH0);
   localparam logic [1:0] ACT_CH1  = 2'(1 << CH1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRAB    = 2'd1,
      ST_WRITE   = 2'd2,
      ST_RELEASE = 2'd3
   } feeder_state_e;

endpackage

// File: rtl/nh_lcd_feeder_timeout.sv
// nh_lcd_feeder_timeout: idle-cycle counter for partial-block release.
// Counts cycles while i_run is high, restarts on i_clear, and saturates with
// o_expire held high once TIMEOUT_CYCLES idle cycles have elapsed.
// Only instantiated when NH_LCD_FEEDER_TIMEOUT_EN is defined.
module nh_lcd_feeder_timeout #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic i_run,
   input  logic i_clear,
   output logic o_expire
);

   localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Expiry is decoded from the register only, so it never depends on the
   // same-cycle handshake that it in turn gates.
   assign o_expire = (cnt_q == LIMIT);

   // Next count: clear wins, otherwise advance while idle until the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (i_clear) begin
         cnt_d = '0;
      end else if (i_run && !o_expire) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/nh_lcd_fifo_feeder.sv
// nh_lcd_fifo_feeder: moves a valid/ready pixel-word stream into one channel
// of the LCD controller's ping-pong pixel FIFO at a time. A channel is owned
// until it is full, the frame ends, or the feeder is disabled; the block that
// ends a frame is released at once and flagged with o_frame_done.
// Build macro NH_LCD_FEEDER_TIMEOUT_EN: additionally release a partial block
// after TIMEOUT_CYCLES idle cycles (no timer exists when it is undefined).
//
// Handshake: o_pixel_ready depends only on state, counters and configuration,
// never on i_pixel_stb. A word transfers on every rising clk edge where
// i_pixel_stb && o_pixel_ready; it appears on o_fifo_data with o_fifo_stb
// exactly one cycle later, with no stall and no drop.
module nh_lcd_fifo_feeder
   import nh_lcd_pkg::*;
#(
   parameter int PIXEL_CNT_WIDTH = 32,
   parameter int TIMEOUT_CYCLES  = 256
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_enable,
   input  logic [PIXEL_CNT_WIDTH-1:0] i_num_pixels,
   input  logic [PIXEL_W-1:0]         i_pixel_data,
   input  logic                       i_pixel_stb,
   output logic                       o_pixel_ready,
   input  logic [1:0]                 i_fifo_rdy,
   output logic [1:0]                 o_fifo_act,
   output logic                       o_fifo_stb,
   input  logic [FIFO_SIZE_W-1:0]     i_fifo_size,
   output logic [PIXEL_W-1:0]         o_fifo_data,
   output logic                       o_frame_done,
   output logic                       o_busy,
   output logic [PIXEL_CNT_WIDTH-1:0] o_pixel_count
);

   feeder_state_e              state_q, state_d;
   logic [1:0]                 act_q, act_d;
   logic [FIFO_SIZE_W-1:0]     blk_cnt_q, blk_cnt_d;
   logic [PIXEL_CNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
   logic                       stb_q, stb_d;
   logic [PIXEL_W-1:0]         data_q, data_d;
   logic                       done_q, done_d;
   logic                       eof_q, eof_d;

   logic blk_full;
   logic frame_full;
   logic timeout_hit;
   logic exit_write;
   logic accept;

   // ">=" rather than "==" so a size or frame length lowered mid-block still
   // terminates instead of being overrun.
   assign blk_full   = (blk_cnt_q >= i_fifo_size);
   assign frame_full = (i_num_pixels != '0) && (pix_cnt_q >= i_num_pixels);

`ifdef NH_LCD_FEEDER_TIMEOUT_EN
   logic tmo_run;
   logic tmo_clear;

   assign tmo_run   = (state_q == ST_WRITE) && (blk_cnt_q != '0) && !accept;
   assign tmo_clear = (state_q != ST_WRITE) || accept;

   nh_lcd_feeder_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .i_run    (tmo_run),
      .i_clear  (tmo_clear),
      .o_expire (timeout_hit)
   );
`else
   logic unused_timeout_cfg;

   assign timeout_hit        = 1'b0;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

   // Any exit condition also closes the handshake, so no word is accepted in
   // the cycle the block is being given up.
   assign exit_write    = blk_full | frame_full | ~i_enable | timeout_hit;
   assign o_pixel_ready = (state_q == ST_WRITE) && !exit_write;
   assign accept        = o_pixel_ready && i_pixel_stb;

   assign o_fifo_act    = act_q;
   assign o_fifo_stb    = stb_q;
   assign o_fifo_data   = data_q;
   assign o_frame_done  = done_q;
   assign o_busy        = (state_q != ST_IDLE);
   assign o_pixel_count = pix_cnt_q;

   // Next-state and datapath: grab a channel, stream into it, release it.
   always_comb begin
      state_d   = state_q;
      act_d     = act_q;
      blk_cnt_d = blk_cnt_q;
      pix_cnt_d = pix_cnt_q;
      stb_d     = accept;
      data_d    = accept ? i_pixel_data : data_q;
      done_d    = 1'b0;
      eof_d     = eof_q;

      case (state_q)
         ST_IDLE: begin
            if (i_enable && (i_fifo_rdy != 2'b00)) begin
               state_d = ST_GRAB;
            end
         end
         ST_GRAB: begin
            act_d     = i_fifo_rdy[CH0] ? ACT_CH0 : ACT_CH1;
            blk_cnt_d = '0;
            state_d   = ST_WRITE;
         end
         ST_WRITE: begin
            if (accept) begin
               blk_cnt_d = blk_cnt_q + FIFO_SIZE_W'(1);
               pix_cnt_d = pix_cnt_q + PIXEL_CNT_WIDTH'(1);
            end else if (exit_write) begin
               // The strobe for the last accepted word is already on the
               // port this cycle, so ownership only drops after it.
               eof_d   = frame_full;
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            act_d = ACT_NONE;
            if (eof_q) begin
               done_d    = 1'b1;
               pix_cnt_d = '0;
            end
            eof_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, ownership, counters and the registered write port.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         act_q     <= ACT_NONE;
         blk_cnt_q <= '0;
         pix_cnt_q <= '0;
         stb_q     <= 1'b0;
         data_q    <= '0;
         done_q    <= 1'b0;
         eof_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         act_q     <= act_d;
         blk_cnt_q <= blk_cnt_d;
         pix_cnt_q <= pix_cnt_d;
         stb_q     <= stb_d;
         data_q    <= data_d;
         done_q    <= done_d;
         eof_q     <= eof_d;
      end
   end

endmodule
